// File: rtl/mem_stage_dmem.sv
// MEM stage: EX/MEM request responder with an internal word-wide data RAM.
// Byte/half/word loads and stores, fixed wait states, registered MEM/WB bundle.
module mem_stage_dmem #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_valid,
  input  logic        mem_MemRW,
  input  logic        mem_MemRd,
  input  logic [2:0]  mem_funct3,
  input  logic [31:0] mem_ALU_out,
  input  logic [31:0] mem_DataB,
  input  logic [4:0]  mem_rd,
  input  logic [1:0]  mem_WBSel,
  input  logic [31:0] mem_pc,
  output logic        stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [1:0]  wb_WBSel,
  output logic [31:0] wb_ALU_out,
  output logic [31:0] wb_mem_data,
  output logic [31:0] wb_pc,
  output logic        wb_misalign
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t state;
  state_t state_nx;
  logic [3:0] cnt;
  logic [3:0] cnt_nx;
  logic stall_i;
  logic complete;

  logic access;
  logic is_st;
  logic is_ld;
  logic bad_f3;
  logic mis;
  logic err;

  logic [AW-1:0] widx;
  logic [1:0] boff;
  logic [31:0] rword;
  logic [7:0] rbyte;
  logic [15:0] rhalf;
  logic [31:0] ldata;
  logic [3:0] be;
  logic [31:0] wdata;

  logic [31:0] ram [DEPTH_WORDS];

  assign access = mem_valid & (mem_MemRW | mem_MemRd);
  assign is_st = mem_MemRW;
  assign is_ld = mem_MemRd & ~mem_MemRW;
  assign widx = mem_ALU_out[AW+1:2];
  assign boff = mem_ALU_out[1:0];
  assign rword = ram[widx];

  // Illegal funct3 and alignment check for the current request
  always_comb begin
    bad_f3 = 1'b0;
    mis = 1'b0;
    if (is_st) begin
      bad_f3 = mem_funct3[2] | (mem_funct3[1:0] == 2'b11);
    end else begin
      bad_f3 = (mem_funct3[1:0] == 2'b11)
             | (mem_funct3[2] & mem_funct3[1]);
    end
    unique case (1'b1)
      (mem_funct3[1:0] == 2'b01): mis = boff[0];
      (mem_funct3[1:0] == 2'b10): mis = |boff;
      default: mis = 1'b0;
    endcase
  end

  assign err = access & (bad_f3 | mis);

  // Store lane enables with the data replicated across lanes
  always_comb begin
    be = 4'b0000;
    wdata = mem_DataB;
    unique case (1'b1)
      (mem_funct3[1:0] == 2'b00): begin
        be = 4'b0001 << boff;
        wdata = {4{mem_DataB[7:0]}};
      end
      (mem_funct3[1:0] == 2'b01): begin
        be = boff[1] ? 4'b1100 : 4'b0011;
        wdata = {2{mem_DataB[15:0]}};
      end
      (mem_funct3[1:0] == 2'b10): begin
        be = 4'b1111;
      end
      default: be = 4'b0000;
    endcase
  end

  // Load lane select and sign/zero extension
  always_comb begin
    rbyte = rword[7:0];
    unique case (boff)
      2'd0: rbyte = rword[7:0];
      2'd1: rbyte = rword[15:8];
      2'd2: rbyte = rword[23:16];
      2'd3: rbyte = rword[31:24];
      default: rbyte = rword[7:0];
    endcase
    rhalf = boff[1] ? rword[31:16] : rword[15:0];
    case (mem_funct3)
      3'b000: ldata = {{24{rbyte[7]}}, rbyte};
      3'b001: ldata = {{16{rhalf[15]}}, rhalf};
      3'b010: ldata = rword;
      3'b100: ldata = {24'd0, rbyte};
      3'b101: ldata = {16'd0, rhalf};
      default: ldata = 32'd0;
    endcase
  end

  // Wait-state sequencing: stall on entry and while the counter runs
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    stall_i = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (access && !err && (WS != 4'd0)) begin
          stall_i = 1'b1;
          state_nx = S_WAIT;
          cnt_nx = WS - 4'd1;
        end
      end
      S_WAIT: begin
        if (cnt != 4'd0) begin
          stall_i = 1'b1;
          cnt_nx = cnt - 4'd1;
        end else begin
          state_nx = S_IDLE;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign stall = rst_n & stall_i;
  assign complete = rst_n & ~stall_i;

  // FSM state and wait counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt <= 4'd0;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
    end
  end

  // RAM write commits on the completion edge of a legal store
  always_ff @(posedge clk) begin
    if (complete && access && is_st && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) ram[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // MEM/WB register: bubble on stall, load on completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_valid <= 1'b0;
      wb_rd <= 5'd0;
      wb_WBSel <= 2'd0;
      wb_ALU_out <= 32'd0;
      wb_mem_data <= 32'd0;
      wb_pc <= 32'd0;
      wb_misalign <= 1'b0;
    end else if (stall_i) begin
      wb_valid <= 1'b0;
    end else begin
      wb_valid <= mem_valid;
      wb_rd <= mem_rd;
      wb_WBSel <= mem_WBSel;
      wb_ALU_out <= mem_ALU_out;
      wb_mem_data <= (access && is_ld && !err) ? ldata : 32'd0;
      wb_pc <= mem_pc;
      wb_misalign <= err;
    end
  end

endmodule
